// File: rtl/pcm_pkg.sv
// Shared types and widths for the PCM SDRAM reader and its sample FIFO.
package pcm_pkg;

  localparam int unsigned SDRAM_AW = 25;
  localparam int unsigned SAMPLE_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } pcm_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output and synchronous flush.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Pop on empty is dropped; push on full only lands when a pop frees the slot.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pcm_sdram_reader.sv
// PCM requester on the SDRAM arbiter: one burst per grant window into a
// sample FIFO, drained to the I2S serializer over a valid/ready stream.
module pcm_sdram_reader
  import pcm_pkg::*;
#(
  parameter int unsigned          FIFO_DEPTH = 512,
  parameter int unsigned          BURST_LEN  = 256,
  parameter logic [SDRAM_AW-1:0]  BASE_ADDR  = 25'h0,
  parameter logic [SDRAM_AW-1:0]  END_ADDR   = 25'h1FFFFF,
  parameter bit                   LOOP       = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play_i,
  input  logic                 restart_i,
  input  logic                 sdram_wait_i,
  input  logic                 sdram_ac_i,
  input  logic [SAMPLE_W-1:0]  sdram_data_i,
  output logic                 sdram_rd_c_o,
  output logic [SDRAM_AW-1:0]  sdram_addr_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [SAMPLE_W-1:0]  sample_data_o,
  output logic                 sample_valid_o,
  input  logic                 sample_ready_i,
  output logic                 eos_o,
  output logic                 underrun_o
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BCW = $clog2(BURST_LEN) + 1;

  pcm_state_e          state_q, state_d;
  logic [SDRAM_AW-1:0] addr_q, addr_d;
  logic [BCW-1:0]      cnt_q, cnt_d;
  logic                eos_q, eos_d;
  logic                pend_q, pend_d;
  logic                busy_q, done_q, underrun_q;

  logic                push, pop, flush, apply_restart;
  logic                fifo_full, fifo_empty;
  logic [CW-1:0]       fifo_count, free;
  logic                burst_ok;

  assign free     = CW'(FIFO_DEPTH) - fifo_count;
  assign burst_ok = (free >= CW'(BURST_LEN));
  assign pop      = sample_ready_i && !fifo_empty;

  // Read request drops combinationally when the arbiter pulls the grant.
  assign sdram_rd_c_o   = (state_q == READ) && !sdram_wait_i;
  assign sdram_addr_o   = addr_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign eos_o          = eos_q;
  assign underrun_o     = underrun_q;
  assign sample_valid_o = !fifo_empty;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    eos_d         = eos_q;
    pend_d        = pend_q;
    push          = 1'b0;
    apply_restart = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (restart_i) apply_restart = 1'b1;
        if (!sdram_wait_i) begin
          state_d = (play_i && !eos_q && burst_ok) ? READ : DONE;
          cnt_d   = '0;
        end
      end
      READ: begin
        pend_d = pend_q || restart_i;
        if (sdram_wait_i) begin
          state_d = DONE;
        end else if (sdram_ac_i) begin
          push   = !fifo_full;
          cnt_d  = cnt_q + BCW'(1);
          addr_d = (LOOP && addr_q == END_ADDR) ? BASE_ADDR : addr_q + SDRAM_AW'(1);
          if (!LOOP && addr_q == END_ADDR) begin
            eos_d   = 1'b1;
            state_d = DONE;
          end else if (cnt_q == BCW'(BURST_LEN - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // A restart seen mid-burst is applied as the window is handed back.
        state_d       = RELEASE;
        apply_restart = restart_i || pend_q;
        pend_d        = 1'b0;
      end
      RELEASE: begin
        if (restart_i) apply_restart = 1'b1;
        if (sdram_wait_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (apply_restart) begin
      addr_d = BASE_ADDR;
      eos_d  = 1'b0;
    end
  end

  assign flush = apply_restart;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= BASE_ADDR;
      cnt_q      <= '0;
      eos_q      <= 1'b0;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      eos_q      <= eos_d;
      pend_q     <= pend_d;
      busy_q     <= (state_d == READ);
      done_q     <= (state_d == DONE);
      underrun_q <= sample_ready_i && fifo_empty && !eos_q;
    end
  end

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (sdram_data_i),
    .head_o  (sample_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_pcm_sdram_reader.sv
// Bench for pcm_sdram_reader: a looping instance checked every cycle against a
// window-level model, and a stop-at-end instance checked with directed values.
module tb_pcm_sdram_reader;

  localparam int unsigned DEPTH = 512;
  localparam int unsigned BURST = 256;
  localparam logic [24:0] A_END = 25'd99;
  localparam logic [24:0] B_END = 25'd10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_play, a_restart, a_wait, a_ac, a_rd, a_busy, a_done;
  logic        a_svalid, a_sready, a_eos, a_under;
  logic [15:0] a_data, a_sdata;
  logic [24:0] a_addr;
  logic        b_play, b_restart, b_wait, b_ac, b_rd, b_busy, b_done;
  logic        b_svalid, b_sready, b_eos, b_under;
  logic [15:0] b_data, b_sdata;
  logic [24:0] b_addr;

  int          cyc = 0;
  int          a_ack_div = 1;
  logic [15:0] salt = 16'h0;

  function automatic logic [15:0] dfn(input logic [24:0] a);
    return (a[15:0] * 16'd7) ^ 16'hBEEF;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  assign a_ac   = a_rd && ((cyc % a_ack_div) == 0);
  assign a_data = dfn(a_addr) ^ salt;
  assign b_ac   = b_rd;
  assign b_data = dfn(b_addr);

  pcm_sdram_reader #(.FIFO_DEPTH(DEPTH), .BURST_LEN(BURST), .BASE_ADDR(25'h0),
                     .END_ADDR(A_END), .LOOP(1'b1)) dut_a (
    .clk(clk), .reset(reset), .play_i(a_play), .restart_i(a_restart),
    .sdram_wait_i(a_wait), .sdram_ac_i(a_ac), .sdram_data_i(a_data),
    .sdram_rd_c_o(a_rd), .sdram_addr_o(a_addr), .busy_o(a_busy), .done_o(a_done),
    .sample_data_o(a_sdata), .sample_valid_o(a_svalid), .sample_ready_i(a_sready),
    .eos_o(a_eos), .underrun_o(a_under));

  pcm_sdram_reader #(.FIFO_DEPTH(DEPTH), .BURST_LEN(BURST), .BASE_ADDR(25'h0),
                     .END_ADDR(B_END), .LOOP(1'b0)) dut_b (
    .clk(clk), .reset(reset), .play_i(b_play), .restart_i(b_restart),
    .sdram_wait_i(b_wait), .sdram_ac_i(b_ac), .sdram_data_i(b_data),
    .sdram_rd_c_o(b_rd), .sdram_addr_o(b_addr), .busy_o(b_busy), .done_o(b_done),
    .sample_data_o(b_sdata), .sample_valid_o(b_svalid), .sample_ready_i(b_sready),
    .eos_o(b_eos), .underrun_o(b_under));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Window-level model of instance A: phase of the grant window, expected
  // sample queue and next expected word address.
  typedef enum {P_IDLE, P_BURST, P_DONE, P_REL} phase_e;
  phase_e      ph = P_IDLE;
  logic [15:0] q[$];
  logic [24:0] m_addr = '0;
  int          wcnt = 0;
  bit          m_under = 1'b0;
  bit          chk_en = 1'b0;
  int          reads_total = 0, done_total = 0, under_total = 0;

  always @(negedge clk) begin : model
    int sz;
    sz = q.size();
    if (chk_en) begin
      check("a_rd", 32'(a_rd), 32'(ph == P_BURST && !a_wait));
      check("a_busy", 32'(a_busy), 32'(ph == P_BURST));
      check("a_done", 32'(a_done), 32'(ph == P_DONE));
      check("a_valid", 32'(a_svalid), 32'(sz != 0));
      if (sz != 0) check("a_head", 32'(a_sdata), 32'(q[0]));
      check("a_underrun", 32'(a_under), 32'(m_under));
      check("a_eos", 32'(a_eos), 32'd0);
      if (a_rd) check("a_addr", 32'(a_addr), 32'(m_addr));
    end
    if (a_rd && a_ac) reads_total++;
    if (a_done) done_total++;
    if (a_under) under_total++;
    if (reset) begin
      q.delete();
      ph      = P_IDLE;
      m_addr  = '0;
      m_under = 1'b0;
      wcnt    = 0;
      chk_en  = 1'b1;
    end else begin
      m_under = a_sready && (sz == 0);
      if (a_sready && sz != 0) void'(q.pop_front());
      case (ph)
        P_IDLE: if (!a_wait) begin
          ph   = (a_play && (int'(DEPTH) - sz) >= int'(BURST)) ? P_BURST : P_DONE;
          wcnt = 0;
        end
        P_BURST: begin
          if (a_wait) ph = P_DONE;
          else if (a_ac) begin
            q.push_back(dfn(m_addr) ^ salt);
            m_addr = (m_addr == A_END) ? 25'd0 : m_addr + 25'd1;
            wcnt++;
            if (wcnt == int'(BURST)) ph = P_DONE;
          end
        end
        P_DONE: ph = P_REL;
        P_REL:  if (a_wait) ph = P_IDLE;
        default: ph = P_IDLE;
      endcase
    end
  end

  int          b_reads = 0;
  logic [24:0] b_last = '0;
  always @(negedge clk) begin
    if (b_rd && b_ac) begin
      b_reads++;
      b_last = b_addr;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit use_b, input int limit, input string nm, output int k);
    k = 0;
    @(negedge clk);
    while (((use_b ? b_done : a_done) !== 1'b1) && k < limit) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_done_seen"}, 32'(k < limit), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int k, r0, d0, u0;
    reset = 1'b1;
    a_play = 1'b0; a_restart = 1'b0; a_wait = 1'b1; a_sready = 1'b0;
    b_play = 1'b0; b_restart = 1'b0; b_wait = 1'b1; b_sready = 1'b0;
    tick(3);
    reset = 1'b0;
    check("rst_a_addr", 32'(a_addr), 32'd0);
    check("rst_a_rd", 32'(a_rd), 32'd0);
    check("rst_a_valid", 32'(a_svalid), 32'd0);
    check("rst_a_done", 32'(a_done), 32'd0);
    check("rst_b_addr", 32'(b_addr), 32'd0);
    check("rst_b_eos", 32'(b_eos), 32'd0);

    // Full burst, ack every cycle; address wraps 99 -> 0 twice.
    a_play = 1'b1; salt = 16'h1111; a_ack_div = 1;
    r0 = reads_total; a_wait = 1'b0;
    wait_done(1'b0, 400, "t1", k);
    check("t1_reads", 32'(reads_total - r0), 32'd256);
    check("t1_next_addr", 32'(m_addr), 32'd56);
    check("t1_fifo_level", 32'(q.size()), 32'd256);
    a_wait = 1'b1; tick(2);

    // Ack every third cycle: address must hold between acks.
    salt = 16'h2222; a_ack_div = 3;
    r0 = reads_total; a_wait = 1'b0;
    wait_done(1'b0, 1000, "t2", k);
    check("t2_reads", 32'(reads_total - r0), 32'd256);
    check("t2_next_addr", 32'(m_addr), 32'd12);
    a_wait = 1'b1; tick(2);

    // Drain to 300 entries: free is 212, so the grant returns done with no reads.
    a_sready = 1'b1; tick(212); a_sready = 1'b0;
    check("t3_fifo_level", 32'(q.size()), 32'd300);
    r0 = reads_total; a_wait = 1'b0;
    wait_done(1'b0, 5, "t3", k);
    check("t3_latency", 32'(k), 32'd1);
    check("t3_reads", 32'(reads_total - r0), 32'd0);
    a_wait = 1'b1; tick(2);

    // Drain completely, then hold ready on the empty FIFO.
    a_sready = 1'b1; k = 0;
    while (q.size() != 0 && k < 2000) begin tick(1); k++; end
    check("t6_drained", 32'(k < 2000), 32'd1);
    a_sready = 1'b0; tick(2);
    u0 = under_total;
    a_sready = 1'b1; tick(4); a_sready = 1'b0; tick(3);
    check("t6_underruns", 32'(under_total - u0), 32'd4);

    // Grant pulled after 19 words: no word lost, next window resumes at 31.
    salt = 16'h3333; a_ack_div = 1;
    r0 = reads_total; a_wait = 1'b0;
    tick(20); a_wait = 1'b1;
    wait_done(1'b0, 5, "t7", k);
    check("t7_latency", 32'(k), 32'd1);
    check("t7_reads", 32'(reads_total - r0), 32'd19);
    check("t7_next_addr", 32'(m_addr), 32'd31);
    tick(2);

    // Reset in the middle of a burst: read drops, FIFO empties, no done.
    salt = 16'h4444; a_wait = 1'b0;
    tick(10);
    d0 = done_total;
    reset = 1'b1; a_wait = 1'b1;
    tick(1);
    check("t8_rd", 32'(a_rd), 32'd0);
    check("t8_valid", 32'(a_svalid), 32'd0);
    check("t8_busy", 32'(a_busy), 32'd0);
    check("t8_addr", 32'(a_addr), 32'd0);
    reset = 1'b0; tick(3);
    check("t8_no_done", 32'(done_total - d0), 32'd0);

    // Stop-at-end instance: 11 words (0..10), eos set, done.
    b_play = 1'b1; r0 = b_reads; b_wait = 1'b0;
    wait_done(1'b1, 40, "t4", k);
    check("t4_reads", 32'(b_reads - r0), 32'd11);
    check("t4_last_addr", 32'(b_last), 32'd10);
    check("t4_eos", 32'(b_eos), 32'd1);
    b_wait = 1'b1; tick(2);
    r0 = b_reads; b_wait = 1'b0;
    wait_done(1'b1, 5, "t4b", k);
    check("t4b_latency", 32'(k), 32'd1);
    check("t4b_reads", 32'(b_reads - r0), 32'd0);
    check("t4b_valid", 32'(b_svalid), 32'd1);

    // Restart while the window is held in RELEASE takes effect at once.
    b_restart = 1'b1; tick(1); b_restart = 1'b0;
    check("t9_eos", 32'(b_eos), 32'd0);
    check("t9_flushed", 32'(b_svalid), 32'd0);
    check("t9_addr", 32'(b_addr), 32'd0);
    b_wait = 1'b1; tick(2);

    // Restart during READ is held until the window is handed back.
    r0 = b_reads; b_wait = 1'b0;
    tick(3); b_restart = 1'b1; tick(1); b_restart = 1'b0;
    check("t10_mid_addr", 32'(b_addr), 32'd3);
    wait_done(1'b1, 40, "t10", k);
    check("t10_reads", 32'(b_reads - r0), 32'd11);
    check("t10_last_addr", 32'(b_last), 32'd10);
    check("t10_eos", 32'(b_eos), 32'd0);
    check("t10_flushed", 32'(b_svalid), 32'd0);
    check("t10_addr", 32'(b_addr), 32'd0);
    b_wait = 1'b1; tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
